// File: rtl/bloom_bitarray_arbiter_if.sv
// ---------------------------------------------------------------------------
// bloom_bitarray_arbiter_if
//
// Bundles every handshake and RAM-bus signal of the Bloom-filter bit-array
// arbiter. The clock and reset stay outside the interface as plain ports.
//
// Signal summary (K = NUM_HASH):
//   ins_valid / ins_ready / ins_idx[K*ADDR_W]   insert (learn) request
//   qry_valid / qry_ready / qry_idx[K*ADDR_W]   query (lookup) request
//   res_valid / res_hit / res_ready             query result handshake
//   clr_req / clr_busy                          whole-array clear request
//   busy                                        arbiter not idle
//   mem_addr / mem_we / mem_din / mem_dout      single-port 1-bit RAM bus
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (hash stage, decision FSM, RAM)
// ---------------------------------------------------------------------------
interface bloom_bitarray_arbiter_if #(
  parameter int ADDR_W   = 3,
  parameter int NUM_HASH = 3
);
  logic                         ins_valid;
  logic                         ins_ready;
  logic [NUM_HASH*ADDR_W-1:0]   ins_idx;
  logic                         qry_valid;
  logic                         qry_ready;
  logic [NUM_HASH*ADDR_W-1:0]   qry_idx;
  logic                         res_valid;
  logic                         res_hit;
  logic                         res_ready;
  logic                         clr_req;
  logic                         clr_busy;
  logic                         busy;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_we;
  logic                         mem_din;
  logic                         mem_dout;

  modport slave (
    input  ins_valid, ins_idx, qry_valid, qry_idx, res_ready, clr_req, mem_dout,
    output ins_ready, qry_ready, res_valid, res_hit, clr_busy, busy,
           mem_addr, mem_we, mem_din
  );

  modport master (
    output ins_valid, ins_idx, qry_valid, qry_idx, res_ready, clr_req, mem_dout,
    input  ins_ready, qry_ready, res_valid, res_hit, clr_busy, busy,
           mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/bloom_bitarray_arbiter.sv
// ---------------------------------------------------------------------------
// bloom_bitarray_arbiter
//
// Sequencer/arbiter for the Bloom-filter bit array (single-port RAM, 1 bit
// wide, 1-cycle read latency). Three requesters share the RAM: insert,
// query and a clear engine. Each accepted request is expanded into one RAM
// cycle per hash index; a query ANDs its K read bits into a hit flag.
//
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active high (RAM contents are untouched)
//   bus  - bloom_bitarray_arbiter_if.slave, carrying the insert, query,
//          result, clear and RAM signals
//
// Parameters:
//   ADDR_W    bit-array address width (array holds 2**ADDR_W bits)
//   NUM_HASH  indices per request (K >= 1)
//
// Build option:
//   BLOOM_RR_ARB_EN  defined   -> round-robin insert/query arbitration
//                    undefined -> fixed priority, insert over query
// ---------------------------------------------------------------------------
module bloom_bitarray_arbiter #(
  parameter int ADDR_W   = 3,
  parameter int NUM_HASH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  bloom_bitarray_arbiter_if.slave    bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INS  = 3'd1;
  localparam logic [2:0] ST_QRD  = 3'd2;
  localparam logic [2:0] ST_QWT  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;
  localparam logic [2:0] ST_CLR  = 3'd5;

  localparam int IDX_W = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam int REQ_W = NUM_HASH * ADDR_W;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_HASH - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  logic [2:0]        state_reg,   state_next;
  logic [IDX_W-1:0]  idx_cnt_reg, idx_cnt_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic [REQ_W-1:0]  req_idx_reg, req_idx_next;
  logic              hit_reg,     hit_next;
  logic              rd_pend_reg, rd_pend_next;
  logic              clr_pend_reg, clr_pend_next;
`ifdef BLOOM_RR_ARB_EN
  // 1 = query gets the grant on the next insert/query collision.
  logic              qry_first_reg, qry_first_next;
`endif

  // Latched request indices, unpacked so the counter can select one.
  logic [ADDR_W-1:0] idx_arr [NUM_HASH];

  generate
    for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_unpack
      assign idx_arr[gi] = req_idx_reg[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration. Requests are only accepted in IDLE with no clear waiting.
  // Each ready looks at the other port's valid, never at its own.
  // -------------------------------------------------------------------------
  logic arb_open;
  logic ins_win;
  logic qry_win;
  logic ins_take;
  logic qry_take;

  assign arb_open = (state_reg == ST_IDLE) && !clr_pend_reg && !rst;

`ifdef BLOOM_RR_ARB_EN
  assign ins_win = !(bus.qry_valid && qry_first_reg);
  assign qry_win = !bus.ins_valid || qry_first_reg;
`else
  assign ins_win = 1'b1;
  assign qry_win = !bus.ins_valid;
`endif

  assign bus.ins_ready = arb_open && ins_win;
  assign bus.qry_ready = arb_open && qry_win;

  assign ins_take = bus.ins_ready && bus.ins_valid;
  assign qry_take = bus.qry_ready && bus.qry_valid;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    idx_cnt_next  = idx_cnt_reg;
    clr_cnt_next  = clr_cnt_reg;
    req_idx_next  = req_idx_reg;
    hit_next      = hit_reg;
    // A read issued in QRD returns its data one cycle later, so the
    // accumulator is updated in the cycle after each QRD cycle.
    rd_pend_next  = (state_reg == ST_QRD);
    clr_pend_next = clr_pend_reg | bus.clr_req;
`ifdef BLOOM_RR_ARB_EN
    qry_first_next = qry_first_reg;
`endif

    if (rd_pend_reg) begin
      hit_next = hit_reg & bus.mem_dout;
    end

    case (state_reg)
      ST_IDLE: begin
        if (clr_pend_reg) begin
          // Every pulse seen up to and including this cycle is covered by
          // the sweep that starts now.
          state_next    = ST_CLR;
          clr_cnt_next  = '0;
          clr_pend_next = 1'b0;
        end else if (ins_take) begin
          state_next   = ST_INS;
          req_idx_next = bus.ins_idx;
          idx_cnt_next = '0;
`ifdef BLOOM_RR_ARB_EN
          qry_first_next = 1'b1;
`endif
        end else if (qry_take) begin
          state_next   = ST_QRD;
          req_idx_next = bus.qry_idx;
          idx_cnt_next = '0;
          hit_next     = 1'b1;
`ifdef BLOOM_RR_ARB_EN
          qry_first_next = 1'b0;
`endif
        end
      end

      ST_INS: begin
        if (idx_cnt_reg == IDX_LAST) begin
          state_next = ST_IDLE;
        end else begin
          idx_cnt_next = idx_cnt_reg + 1'b1;
        end
      end

      ST_QRD: begin
        if (idx_cnt_reg == IDX_LAST) begin
          state_next = ST_QWT;
        end else begin
          idx_cnt_next = idx_cnt_reg + 1'b1;
        end
      end

      // Waits for the final read bit to land in the accumulator.
      ST_QWT: begin
        state_next = ST_RESP;
      end

      ST_RESP: begin
        if (bus.res_ready) begin
          state_next = ST_IDLE;
        end
      end

      ST_CLR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_cnt_reg  <= '0;
      clr_cnt_reg  <= '0;
      req_idx_reg  <= '0;
      hit_reg      <= 1'b0;
      rd_pend_reg  <= 1'b0;
      clr_pend_reg <= 1'b0;
`ifdef BLOOM_RR_ARB_EN
      qry_first_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_cnt_reg  <= idx_cnt_next;
      clr_cnt_reg  <= clr_cnt_next;
      req_idx_reg  <= req_idx_next;
      hit_reg      <= hit_next;
      rd_pend_reg  <= rd_pend_next;
      clr_pend_reg <= clr_pend_next;
`ifdef BLOOM_RR_ARB_EN
      qry_first_reg <= qry_first_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Write enable is gated by rst so an operation interrupted by
  // reset issues no write in the reset cycle itself.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.mem_din  = 1'b0;
    case (state_reg)
      ST_INS: begin
        bus.mem_addr = idx_arr[idx_cnt_reg];
        bus.mem_we   = !rst;
        bus.mem_din  = 1'b1;
      end
      ST_QRD: begin
        bus.mem_addr = idx_arr[idx_cnt_reg];
      end
      ST_CLR: begin
        bus.mem_addr = clr_cnt_reg;
        bus.mem_we   = !rst;
      end
      default: begin
        bus.mem_addr = '0;
      end
    endcase
  end

  assign bus.res_valid = (state_reg == ST_RESP);
  assign bus.res_hit   = (state_reg == ST_RESP) && hit_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.clr_busy  = clr_pend_reg || (state_reg == ST_CLR);

endmodule

// File: tb/tb_bloom_bitarray_arbiter.sv
module tb_bloom_bitarray_arbiter;
  localparam int AW    = 3;
  localparam int K     = 3;
  localparam int RW    = AW * K;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bloom_bitarray_arbiter_if #(.ADDR_W(AW), .NUM_HASH(K)) bus ();

  bloom_bitarray_arbiter #(.ADDR_W(AW), .NUM_HASH(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bit-array RAM: 1-bit wide, registered read. Starts all ones so the
  // first sweep has something to erase.
  logic ram [DEPTH] = '{default: 1'b1};
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_din;
    else                     bus.mem_dout <= ram[bus.mem_addr];
  end

  // Every RAM write, logged mid-cycle as {din, addr}.
  logic [AW:0] wr_log [$];
  always @(negedge clk) begin
    #2;
    if (bus.mem_we === 1'b1) wr_log.push_back({bus.mem_din, bus.mem_addr});
  end

  // Reference model: which bits of the filter are set, and whose turn it
  // is on an insert/query collision.
  bit model_bits [DEPTH];
  bit ins_turn = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic model_hit(input logic [RW-1:0] idx);
    logic h = 1'b1;
    for (int i = 0; i < K; i++) h = h & model_bits[idx[i*AW +: AW]];
    return h;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sweep(input string tag, input int reps);
    int n = 0;
    #2;
    while (bus.clr_busy !== 1'b0 && n < 60) begin
      @(negedge clk); #3; n++;
    end
    check({tag, "_done"}, 32'(n < 60), 32'd1);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(reps * DEPTH));
    for (int i = 0; i < wr_log.size(); i++)
      check({tag, "_wr"}, 32'(wr_log[i]), 32'({1'b0, AW'(i % DEPTH)}));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) model_bits[i] = 1'b0;
  endtask

  task automatic do_clear(input string tag, input int second);
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    #1;
    check({tag, "_cbusy"}, 32'({bus.clr_busy, bus.ins_ready, bus.qry_ready}), 32'b100);
    wr_log.delete();
    if (second > 0) begin
      repeat (second) @(negedge clk);
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
    end
    wait_sweep(tag, (second > 0) ? 2 : 1);
  endtask

  task automatic do_insert(input logic [RW-1:0] idx, input string tag);
    int n = 0;
    wr_log.delete();
    bus.ins_valid = 1'b1;
    bus.ins_idx   = idx;
    #1;
    while (bus.ins_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_acc"}, 32'(n < 40), 32'd1);
    @(negedge clk);
    bus.ins_valid = 1'b0;
    bus.ins_idx   = RW'($urandom);
    for (int i = 0; i < K; i++) model_bits[idx[i*AW +: AW]] = 1'b1;
    ins_turn = 1'b0;
    repeat (K + 1) @(negedge clk);
    #3;
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(K));
    for (int i = 0; i < wr_log.size(); i++)
      check({tag, "_wr"}, 32'(wr_log[i]), 32'({1'b1, idx[i*AW +: AW]}));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    $display("insert %s idx=%0h writes=%0d", tag, idx, wr_log.size());
  endtask

  task automatic do_query(input logic [RW-1:0] idx, input int hold, input bit clr_mid, input string tag);
    int   n = 0;
    logic exp_hit;
    wr_log.delete();
    bus.qry_valid = 1'b1;
    bus.qry_idx   = idx;
    #1;
    while (bus.qry_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_acc"}, 32'(n < 40), 32'd1);
    exp_hit  = model_hit(idx);
    ins_turn = 1'b1;
    @(negedge clk);
    bus.qry_valid = 1'b0;
    bus.qry_idx   = RW'($urandom);
    bus.res_ready = 1'b0;
    bus.clr_req   = clr_mid;
    n = 1;
    #1;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      @(negedge clk); bus.clr_req = 1'b0; #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(K + 2));
    check({tag, "_hit"}, 32'(bus.res_hit), 32'(exp_hit));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, "_hold"},
            32'({bus.res_valid, bus.res_hit, bus.ins_ready, bus.qry_ready, bus.mem_we}),
            32'({1'b1, exp_hit, 3'b000}));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    check({tag, "_idle"}, 32'({bus.busy, bus.res_valid}), 32'd0);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'd0);
    $display("query %s idx=%0h hit=%0b latency=%0d", tag, idx, exp_hit, n);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [RW-1:0] last_ins;
    logic [RW-1:0] q_idx;
    logic          exp_hit;
    bit            exp_q;
    bit            got_q;
    int            n;

    bus.ins_valid = 1'b0; bus.ins_idx = '0;
    bus.qry_valid = 1'b0; bus.qry_idx = '0;
    bus.res_ready = 1'b0; bus.clr_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs",
          32'({bus.ins_ready, bus.qry_ready, bus.res_valid, bus.res_hit, bus.clr_busy,
               bus.busy, bus.mem_we, bus.mem_din, bus.mem_addr}), 32'd0);
    rst = 1'b0;
    $display("reset released");

    // 1. Full sweep
    do_clear("t1_clr", 0);
    $display("clear t1 done");

    // 2. Insert then query same indices
    last_ins = {3'd6, 3'd4, 3'd1};
    do_insert(last_ins, "t2_ins");
    do_query(last_ins, 0, 1'b0, "t2_qry");

    // 3. Miss and duplicate indices
    do_query({3'd7, 3'd4, 3'd1}, 0, 1'b0, "t3_miss");
    do_query({3'd4, 3'd4, 3'd4}, 0, 1'b0, "t3_dup");

    // 4. Both valid together for four grants
    bus.res_ready = 1'b1;
    bus.ins_valid = 1'b1; bus.ins_idx = RW'($urandom);
    bus.qry_valid = 1'b1; bus.qry_idx = RW'($urandom);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(bus.ins_ready === 1'b1 || bus.qry_ready === 1'b1) && n < 40) begin
        @(negedge clk); #1; n++;
      end
      check("t4_wait", 32'(n < 40), 32'd1);
`ifdef BLOOM_RR_ARB_EN
      exp_q = !ins_turn;
`else
      exp_q = 1'b0;
`endif
      check("t4_grant", 32'({bus.ins_ready, bus.qry_ready}), exp_q ? 32'b01 : 32'b10);
      got_q = (bus.qry_ready === 1'b1);
      $display("arb grant %0d -> %s", g, got_q ? "Q" : "I");
      exp_hit = 1'b0;
      if (got_q) begin
        exp_hit  = model_hit(bus.qry_idx);
        ins_turn = 1'b1;
      end else begin
        for (int i = 0; i < K; i++) model_bits[bus.ins_idx[i*AW +: AW]] = 1'b1;
        ins_turn = 1'b0;
      end
      @(negedge clk);
      bus.ins_idx = RW'($urandom);
      bus.qry_idx = RW'($urandom);
      if (got_q) begin
        n = 1;
        #1;
        while (bus.res_valid !== 1'b1 && n < 20) begin
          @(negedge clk); #1; n++;
        end
        check("t4_qlat", 32'(n), 32'(K + 2));
        check("t4_qhit", 32'(bus.res_hit), 32'(exp_hit));
        @(negedge clk);
      end
    end
    bus.ins_valid = 1'b0;
    bus.qry_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (K + 4) @(negedge clk);
    #1;
    check("t4_idle", 32'(bus.busy), 32'd0);

    // 5. Result held for 10 cycles
    do_query(last_ins, 10, 1'b0, "t5_hold");

    // 6a. Clear requested while reading
    do_insert(last_ins, "t6a_ins");
    do_query(last_ins, 0, 1'b1, "t6a_qry");
    check("t6a_cbusy", 32'({bus.clr_busy, bus.ins_ready, bus.qry_ready}), 32'b100);
    wr_log.delete();
    wait_sweep("t6a_clr", 1);
    do_query(last_ins, 0, 1'b0, "t6a_after");

    // Clear requested during a sweep -> second sweep
    do_clear("dbl_clr", 4);
    $display("double clear done");

    // 6b. Reset during insert after one write
    wr_log.delete();
    bus.ins_valid = 1'b1;
    bus.ins_idx   = {3'd5, 3'd3, 3'd2};
    n = 0;
    #1;
    while (bus.ins_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("t6b_acc", 32'(n < 40), 32'd1);
    @(negedge clk);
    bus.ins_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6b_we_in_rst", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    #1;
    check("t6b_outs",
          32'({bus.ins_ready, bus.qry_ready, bus.res_valid, bus.res_hit, bus.clr_busy,
               bus.busy, bus.mem_we, bus.mem_din, bus.mem_addr}), 32'd0);
    rst = 1'b0;
    model_bits[2] = 1'b1;
    ins_turn = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    check("t6b_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) check("t6b_wr", 32'(wr_log[0]), 32'({1'b1, 3'd2}));
    $display("reset mid-insert: writes=%0d", wr_log.size());
    do_query({3'd3, 3'd2, 3'd5}, 0, 1'b0, "t6b_q");
    do_query({3'd2, 3'd2, 3'd2}, 0, 1'b0, "t6b_q2");

    // Randomized traffic against the model
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 9))
        0: do_clear("rnd_clr", 0);
        1, 2, 3, 4: begin
          last_ins = RW'($urandom);
          do_insert(last_ins, "rnd_ins");
        end
        default: begin
          q_idx = ($urandom_range(0, 1) == 1) ? last_ins : RW'($urandom);
          do_query(q_idx, $urandom_range(0, 3), 1'b0, "rnd_qry");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
